// File: rtl/risc_v_mike_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch port and
// the load/store port; one transaction in flight, fixed read latency.
module risc_v_mike_mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_if_req,
  input  logic [ADDR_W-1:0]   i_if_addr,
  output logic                o_if_gnt,
  output logic                o_if_rvalid,
  output logic [DATA_W-1:0]   o_if_rdata,
  input  logic                i_d_req,
  input  logic                i_d_we,
  input  logic [ADDR_W-1:0]   i_d_addr,
  input  logic [DATA_W/8-1:0] i_d_be,
  input  logic [DATA_W-1:0]   i_d_wdata,
  output logic                o_d_gnt,
  output logic                o_d_rvalid,
  output logic [DATA_W-1:0]   o_d_rdata,
  output logic                o_mem_en,
  output logic                o_mem_we,
  output logic [ADDR_W-1:0]   o_mem_addr,
  output logic [DATA_W/8-1:0] o_mem_be,
  output logic [DATA_W-1:0]   o_mem_wdata,
  input  logic [DATA_W-1:0]   i_mem_rdata,
  output logic                o_dbg_busy
);

  // Handshake: a request is held (with its address/data) until the matching
  // gnt is seen high in a cycle; the response rvalid is a single-cycle pulse
  // exactly MEM_LAT cycles after that gnt, with rdata valid only alongside it.

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t     r_state, w_state_nx;
  logic [2:0] r_cnt,   w_cnt_nx;
  logic       r_owner, w_owner_nx;  // 1 = D owns the outstanding transaction
  logic       r_we,    w_we_nx;
  logic       r_last,  w_last_nx;   // 1 = D was granted most recently

  logic w_expire, w_slot, w_gnt_if, w_gnt_d, w_rsp;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 3'd0;
      r_owner <= 1'b0;
      r_we    <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_owner <= w_owner_nx;
      r_we    <= w_we_nx;
      r_last  <= w_last_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_owner_nx = r_owner;
    w_we_nx    = r_we;
    w_last_nx  = r_last;

    // The counter sits at 1 in the cycle the memory data is due.
    w_expire = (r_state == S_BUSY) && (r_cnt == 3'd1);
    w_slot   = i_rst && ((r_state == S_IDLE) || w_expire);
    w_gnt_d  = w_slot && i_d_req && (!i_if_req || !r_last);
    w_gnt_if = w_slot && i_if_req && !w_gnt_d;
    w_rsp    = i_rst && w_expire;

    if (w_gnt_if || w_gnt_d) begin
      w_state_nx = S_BUSY;
      w_cnt_nx   = LAT;
      w_owner_nx = w_gnt_d;
      w_we_nx    = w_gnt_d && i_d_we;
      w_last_nx  = w_gnt_d;
    end else if (w_expire) begin
      w_state_nx = S_IDLE;
      w_cnt_nx   = 3'd0;
    end else if (r_state == S_BUSY) begin
      w_cnt_nx   = r_cnt - 3'd1;
    end
  end

  always_comb begin
    o_if_gnt    = w_gnt_if;
    o_d_gnt     = w_gnt_d;
    o_mem_en    = w_gnt_if || w_gnt_d;
    o_mem_we    = w_gnt_d && i_d_we;
    o_mem_addr  = '0;
    o_mem_be    = '0;
    o_mem_wdata = '0;
    if (w_gnt_d) begin
      o_mem_addr  = i_d_addr;
      o_mem_be    = i_d_be;
      o_mem_wdata = i_d_wdata;
    end else if (w_gnt_if) begin
      o_mem_addr  = i_if_addr;
      o_mem_be    = '1;
    end

    o_if_rvalid = w_rsp && !r_owner;
    o_d_rvalid  = w_rsp && r_owner;
    o_if_rdata  = o_if_rvalid ? i_mem_rdata : '0;
    // A store acknowledge carries no data.
    o_d_rdata   = (o_d_rvalid && !r_we) ? i_mem_rdata : '0;
    o_dbg_busy  = (r_state == S_BUSY);
  end

endmodule
